pc_gen: RTL

- Parametrised program-counter generator at the head of the fetch stage; successor to the single-redirect PC controller.
- Supports N prioritised redirect channels, configurable XLEN and reset vector, and optional compressed-instruction stepping.
- Adds a BOOT/RUN/HALT state machine with halt/resume handshake, redirect-target alignment checking, and a circular history of retired PCs for trap/debug readback.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_hist_buf.sv | 48 ++++
 rtl/pc_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam int unsigned STEP_C = 2;
    localparam int unsigned STEP_I = 4;

    // Low PC bits that must be zero for a legal fetch target.
    function automatic logic [1:0] align_mask(input logic comp_en);
        return comp_en ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_hist_buf.sv
// Circular buffer of previously retired PCs; read index 0 is the most recent entry.
module pc_hist_buf #(
    parameter int unsigned      XLEN       = 64,
    parameter int unsigned      HIST_DEPTH = 4,
    parameter logic [XLEN-1:0]  RST_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [XLEN-1:0]               wr_data,
    input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]               rd_data
);

    localparam int unsigned PTR_W = $clog2(HIST_DEPTH);

    logic [XLEN-1:0]  mem_q [HIST_DEPTH];
    logic [XLEN-1:0]  mem_d [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                mem_q[i] <= RST_VAL;
            end
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Pointer arithmetic wraps naturally because HIST_DEPTH is a power of two.
    assign rd_ptr  = wr_ptr_q - PTR_W'(1) - rd_idx;
    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised redirects, sequential stepping, BOOT/RUN/HALT control and PC history.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [63:0] RESET_PC   = 64'h1000,
    parameter int unsigned NUM_REDIR  = 2,
    parameter bit          COMP_EN    = 1'b1,
    parameter int unsigned HIST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REDIR-1:0]          redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0]     redir_pc,
    input  logic                          stall,
    input  logic                          inst_valid,
    input  logic                          inst_comp,
    input  logic                          halt_req,
    input  logic                          resume_req,
    output logic [XLEN-1:0]               pc,
    output logic                          pc_valid,
    output logic                          halted,
    output logic                          misalign,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_pc
);

    localparam logic [XLEN-1:0] RST_PC   = XLEN'(RESET_PC);
    localparam logic [1:0]      AMASK    = align_mask(COMP_EN);
    localparam logic [XLEN-1:0] CLR_MASK = ~XLEN'(AMASK);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            halted_q, halted_d;
    logic            misalign_q, misalign_d;

    logic            redir_hit;
    logic [XLEN-1:0] redir_tgt;
    logic            tgt_misaligned;
    logic [XLEN-1:0] step_amt;
    logic            hist_we;

    // Descending scan so the lowest asserted channel is the last (winning) assignment.
    always_comb begin
        redir_hit = 1'b0;
        redir_tgt = '0;
        for (int i = int'(NUM_REDIR) - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_hit = 1'b1;
                redir_tgt = redir_pc[i*XLEN +: XLEN];
            end
        end
    end

    assign tgt_misaligned = |(redir_tgt[1:0] & AMASK);
    assign step_amt       = (COMP_EN && inst_comp) ? XLEN'(STEP_C) : XLEN'(STEP_I);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        hist_we    = 1'b0;

        if (redir_hit) begin
            pc_d       = redir_tgt & CLR_MASK;
            misalign_d = tgt_misaligned;
            hist_we    = 1'b1;
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // A coinciding redirect defers halt entry by one cycle.
                if (!redir_hit) begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (!stall && inst_valid) begin
                        pc_d    = pc_q + step_amt;
                        hist_we = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (resume_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        pc_valid_d = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RST_PC;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign halted   = halted_q;
    assign misalign = misalign_q;

    pc_hist_buf #(
        .XLEN       (XLEN),
        .HIST_DEPTH (HIST_DEPTH),
        .RST_VAL    (RST_PC)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (hist_we),
        .wr_data (pc_q),
        .rd_idx  (hist_idx),
        .rd_data (hist_pc)
    );

endmodule
